// File: rtl/led_sequencer.sv
// LED pattern sequencer: four raw push-buttons are synchronised, debounced and turned
// into release events that drive an IDLE/RUN/PAUSE controller stepping a 4-bit pattern.
module led_sequencer #(
  parameter int CLKS_PER_TICK  = 12500000,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  input  logic i_Switch_3,
  input  logic i_Switch_4,
  output logic o_LED_1,
  output logic o_LED_2,
  output logic o_LED_3,
  output logic o_LED_4
);

  localparam int TW = $clog2(CLKS_PER_TICK);
  localparam int DW = $clog2(DEBOUNCE_LIMIT);
  localparam logic [TW-1:0] PER_NORM_M1 = TW'(CLKS_PER_TICK - 1);
  localparam logic [TW-1:0] PER_FAST_M1 = TW'((CLKS_PER_TICK / 4) - 1);
  localparam logic [DW-1:0] DB_MAX      = DW'(DEBOUNCE_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_NEXT  = 3'd1,
    EV_PAUSE = 3'd2,
    EV_SPEED = 3'd3,
    EV_STOP  = 3'd4
  } event_e;

  function automatic logic [3:0] seed_of(input logic [1:0] mode);
    logic [3:0] seed;
    case (mode)
      2'd0:    seed = 4'b1111;
      2'd1:    seed = 4'b0001;
      2'd2:    seed = 4'b0000;
      2'd3:    seed = 4'b0001;
      default: seed = 4'b0000;
    endcase
    return seed;
  endfunction

  function automatic logic [3:0] step_of(input logic [1:0] mode, input logic [3:0] pat,
                                         input logic dir_up);
    logic [3:0] nxt;
    case (mode)
      2'd0:    nxt = ~pat;
      2'd1:    nxt = {pat[2:0], pat[3]};
      2'd2:    nxt = pat + 4'd1;
      2'd3:    nxt = dir_up ? {pat[2:0], 1'b0} : {1'b0, pat[3:1]};
      default: nxt = pat;
    endcase
    return nxt;
  endfunction

  // Bounce direction flips once the lit bit reaches either end of the bar.
  function automatic logic dir_after(input logic [3:0] pat_next, input logic dir_up);
    logic dir;
    if (pat_next == 4'b1000) begin
      dir = 1'b0;
    end else if (pat_next == 4'b0001) begin
      dir = 1'b1;
    end else begin
      dir = dir_up;
    end
    return dir;
  endfunction

  logic [3:0]    raw_s;
  logic [3:0]    sync1_r;
  logic [3:0]    sync2_r;
  logic [3:0]    stable_r;
  logic [3:0]    stable_d_r;
  logic [3:0]    release_r;
  logic [DW-1:0] db_cnt_r [4];

  state_e        state_r;
  logic [1:0]    mode_r;
  logic          fast_r;
  logic          dir_up_r;
  logic [TW-1:0] tick_cnt_r;
  logic [3:0]    pattern_r;

  event_e        ev_s;
  logic [TW-1:0] period_m1_s;
  logic          tick_s;
  logic [3:0]    pattern_step_s;

  assign raw_s = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debouncer: the synced level must differ from the stable level for DEBOUNCE_LIMIT clocks.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      stable_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_MAX) begin
          stable_r[i] <= sync2_r[i];
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
        end
      end
    end
  end

  // Registered one-cycle release pulse on each stable 1->0 edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      stable_d_r <= 4'b0000;
      release_r  <= 4'b0000;
    end else begin
      stable_d_r <= stable_r;
      release_r  <= stable_d_r & ~stable_r;
    end
  end

  // Fixed priority: stop beats pause beats next beats speed; losers are dropped.
  always_comb begin
    ev_s = EV_NONE;
    if (release_r[3]) begin
      ev_s = EV_STOP;
    end else if (release_r[1]) begin
      ev_s = EV_PAUSE;
    end else if (release_r[0]) begin
      ev_s = EV_NEXT;
    end else if (release_r[2]) begin
      ev_s = EV_SPEED;
    end else begin
      ev_s = EV_NONE;
    end
  end

  assign period_m1_s    = fast_r ? PER_FAST_M1 : PER_NORM_M1;
  assign tick_s         = (tick_cnt_r == period_m1_s);
  assign pattern_step_s = step_of(mode_r, pattern_r, dir_up_r);

  // Control FSM; an event acting on an edge takes precedence over a tick on that edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r    <= ST_IDLE;
      mode_r     <= 2'd0;
      fast_r     <= 1'b0;
      dir_up_r   <= 1'b1;
      tick_cnt_r <= '0;
      pattern_r  <= 4'b0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          case (ev_s)
            EV_NEXT: begin
              state_r    <= ST_RUN;
              pattern_r  <= seed_of(mode_r);
              dir_up_r   <= 1'b1;
              tick_cnt_r <= '0;
            end
            EV_SPEED: fast_r <= ~fast_r;
            default: ;
          endcase
        end
        ST_RUN: begin
          case (ev_s)
            EV_STOP: begin
              state_r    <= ST_IDLE;
              pattern_r  <= 4'b0000;
              tick_cnt_r <= '0;
            end
            EV_PAUSE: state_r <= ST_PAUSE;
            EV_NEXT: begin
              mode_r     <= mode_r + 2'd1;
              pattern_r  <= seed_of(mode_r + 2'd1);
              dir_up_r   <= 1'b1;
              tick_cnt_r <= '0;
            end
            EV_SPEED: begin
              fast_r     <= ~fast_r;
              tick_cnt_r <= '0;
            end
            default: begin
              if (tick_s) begin
                pattern_r  <= pattern_step_s;
                dir_up_r   <= dir_after(pattern_step_s, dir_up_r);
                tick_cnt_r <= '0;
              end else begin
                tick_cnt_r <= tick_cnt_r + TW'(1);
              end
            end
          endcase
        end
        ST_PAUSE: begin
          case (ev_s)
            EV_STOP: begin
              state_r    <= ST_IDLE;
              pattern_r  <= 4'b0000;
              tick_cnt_r <= '0;
            end
            EV_PAUSE: state_r <= ST_RUN;
            EV_NEXT: begin
              mode_r     <= mode_r + 2'd1;
              pattern_r  <= seed_of(mode_r + 2'd1);
              dir_up_r   <= 1'b1;
              tick_cnt_r <= '0;
            end
            EV_SPEED: begin
              fast_r     <= ~fast_r;
              tick_cnt_r <= '0;
            end
            default: ;
          endcase
        end
        default: begin
          state_r    <= ST_IDLE;
          pattern_r  <= 4'b0000;
          tick_cnt_r <= '0;
        end
      endcase
    end
  end

  assign o_LED_1 = pattern_r[0];
  assign o_LED_2 = pattern_r[1];
  assign o_LED_3 = pattern_r[2];
  assign o_LED_4 = pattern_r[3];

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 The block SHALL have parameter CLKS_PER_TICK, default 12500000, clocks per pattern step at normal speed (min 8, multiple of 4).
REQ-002 The block SHALL have parameter DEBOUNCE_LIMIT, default 250000, clocks a raw switch level must hold before it is accepted (min 2).
REQ-003 The block SHALL have port i_Clk  input  1  system clock, all logic on rising edge.
REQ-004 The block SHALL have port i_Rst_L  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have ports i_Switch_1..i_Switch_4  input  1 each  raw push-buttons, 1 = pressed; asynchronous to i_Clk.
REQ-006 The block SHALL have ports o_LED_1..o_LED_4  output  1 each  registered LED drives, 1 = lit; o_LED_n = pattern bit n-1.

Function
REQ-007 Each raw switch SHALL pass a 2-flop synchronizer, then a debouncer: counter increments while synced level differs from stable level, clears when equal; at DEBOUNCE_LIMIT-1 stable level takes synced level and counter clears.
REQ-008 A release event SHALL be a one-cycle pulse on debounced stable 1->0; presses (0->1) generate no event.
REQ-009 Switch roles: S1 = next mode/start, S2 = pause/resume, S3 = speed toggle, S4 = stop.
REQ-010 Same-cycle events SHALL be arbitrated S4 > S2 > S1 > S3; only the winner acts, losers are discarded (not queued).
REQ-011 Control FSM states SHALL be IDLE, RUN, PAUSE.
REQ-012 IDLE: pattern 0000, tick counter 0; S1 -> RUN, load seed of current mode; S2, S4 ignored; S3 toggles speed.
REQ-013 RUN: tick counter counts 0..P-1, P = CLKS_PER_TICK (normal) or CLKS_PER_TICK/4 (fast); at count P-1 a tick fires, counter wraps to 0, pattern steps once.
REQ-014 RUN: S1 -> mode+1 (wrap 3->0), load new seed, counter cleared, stay RUN; S2 -> PAUSE; S3 -> toggle speed, counter cleared; S4 -> IDLE.
REQ-015 PAUSE: counter and pattern frozen; S2 -> RUN resuming from held count; S1 -> mode+1 and seed load, stay PAUSE; S3 toggles speed, counter cleared; S4 -> IDLE.
REQ-016 Modes (2-bit) and seeds: 0 BLINK seed 1111, step = invert all; 1 CHASE seed 0001, step = rotate left (1000 -> 0001); 2 BINARY seed 0000, step = +1 mod 16 (1111 -> 0000); 3 BOUNCE seed 0001 dir=up, step = shift toward dir, dir reverses on reaching 1000 or 0001 (1,2,4,8,4,2,1,2...).
REQ-017 Entering IDLE via S4 SHALL clear pattern and counter in the same edge; mode and speed are retained.
REQ-018 Latency: LED outputs SHALL change exactly 2 clocks after the debounced stable level falls (event pulse, then pattern register); tick-driven steps appear on LEDs 1 clock after the tick.
REQ-019 Raw bounce shorter than DEBOUNCE_LIMIT clocks SHALL produce no event and no LED change.

Reset
REQ-020 i_Rst_L low SHALL immediately clear all state regardless of clock: FSM IDLE, mode 0, speed normal, pattern 0000, all outputs 0, counters 0, synchronizers and stable levels 0.
REQ-021 Reset asserted mid-RUN or mid-debounce SHALL discard pending counts and events; no event SHALL be generated by reset release.
REQ-022 Reset deassertion SHALL be consumed synchronously; first state change no earlier than first rising edge after release.

Verification (CLKS_PER_TICK=8, DEBOUNCE_LIMIT=4)
REQ-023 Reset, press/release S1 (each held 10 clks) -> RUN, LEDs 1111, then 0000/1111 alternating every 8 clks.
REQ-024 From RUN mode 0, release S1 three times -> CHASE 0001,0010,0100,1000,0001; BINARY 0000..1111,0000; BOUNCE 0001,0010,0100,1000,0100,0010,0001.
REQ-025 S3 release in RUN -> steps every 2 clks; second S3 -> every 8 clks; counter restarts from 0 each time.
REQ-026 S2 release in CHASE at 0100 -> LEDs hold 0100 for 100 clks; S2 again -> next step 1000 after remaining count.
REQ-027 S4 and S1 released same cycle in RUN -> IDLE, LEDs 0000, mode unchanged; 2-clk glitch pulses on S1 -> no change.
REQ-028 i_Rst_L low mid-RUN between clock edges -> LEDs 0000 immediately; after release, S2/S4 ignored, S1 starts BLINK 1111.
